// File: rtl/lsu_cache_port_if.sv
// lsu_cache_port_if: pipeline request/response and cache CPU-port signals of the LSU back end.
// master is the LSU itself; slave is the pipeline plus cache facing it.
interface lsu_cache_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              lsu_req_valid;
    logic              lsu_req_we;
    logic [2:0]        lsu_req_funct3;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic              lsu_stall;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_fault;
    logic [ADDR_W-1:0] cpu2cache_addr;
    logic [DATA_W-1:0] cpu2cache_data_in;
    logic              cpu2cache_rw;
    logic              cpu2cache_valid;
    logic [DATA_W-1:0] cache2cpu_data_out;
    logic              cache2cpu_ready;
    modport master (
        input  lsu_req_valid, lsu_req_we, lsu_req_funct3, lsu_req_addr, lsu_req_wdata,
        output lsu_stall, lsu_rdata, lsu_fault,
        output cpu2cache_addr, cpu2cache_data_in, cpu2cache_rw, cpu2cache_valid,
        input  cache2cpu_data_out, cache2cpu_ready
    );
    modport slave (
        output lsu_req_valid, lsu_req_we, lsu_req_funct3, lsu_req_addr, lsu_req_wdata,
        input  lsu_stall, lsu_rdata, lsu_fault,
        input  cpu2cache_addr, cpu2cache_data_in, cpu2cache_rw, cpu2cache_valid,
        output cache2cpu_data_out, cache2cpu_ready
    );
endinterface

// File: rtl/lsu_cache_port.sv
// lsu_cache_port: RV32I load/store back end turning byte/half/word accesses into word cache transactions.
// Sub-word stores are done as read-modify-write; misaligned or illegal accesses fault without touching the cache.
module lsu_cache_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic             iCLK,
    input logic             iRST_n,
    lsu_cache_port_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fault;
    logic              w_illegal, w_misal, w_fault, w_rdy;
    logic [4:0]        w_shift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load, w_mask, w_merge;
    assign w_rdy     = bus.cache2cpu_ready;
    assign w_illegal = (bus.lsu_req_funct3[1:0] == 2'b11) |
                       (bus.lsu_req_funct3[2] & (bus.lsu_req_funct3[1] | bus.lsu_req_we));
    assign w_misal   = ((bus.lsu_req_funct3[1:0] == 2'b01) & bus.lsu_req_addr[0]) |
                       ((bus.lsu_req_funct3[1:0] == 2'b10) & (|bus.lsu_req_addr[1:0]));
    assign w_fault   = w_illegal | w_misal;
    // Lane offset in bits; halfword accesses are already known to be 2-byte aligned here
    assign w_shift   = {r_addr[1:0], 3'b000};
    assign w_byte    = 8'(bus.cache2cpu_data_out >> w_shift);
    assign w_half    = 16'(bus.cache2cpu_data_out >> w_shift);
    assign w_load    = (r_f3[1:0] == 2'b00) ? {{(DATA_W-8){~r_f3[2] & w_byte[7]}}, w_byte} :
                       (r_f3[1:0] == 2'b01) ? {{(DATA_W-16){~r_f3[2] & w_half[15]}}, w_half} :
                       bus.cache2cpu_data_out;
    assign w_mask    = (r_f3[0] ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF)) << w_shift;
    assign w_merge   = (bus.cache2cpu_data_out & ~w_mask) | ((r_wdata << w_shift) & w_mask);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.lsu_req_valid) w_next = w_fault ? DONE :
                                                     (bus.lsu_req_we & bus.lsu_req_funct3[1]) ? WR_REQ : RD_REQ;
            RD_REQ:  if (w_rdy) w_next = RD_WAIT;
            RD_WAIT: if (w_rdy) w_next = r_we ? WR_REQ : DONE;
            WR_REQ:  if (w_rdy) w_next = WR_WAIT;
            WR_WAIT: if (w_rdy) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.lsu_req_valid) begin
                r_addr  <= bus.lsu_req_addr;
                r_f3    <= bus.lsu_req_funct3;
                r_we    <= bus.lsu_req_we;
                r_wdata <= bus.lsu_req_wdata;
                if (w_fault) begin
                    r_fault <= 1'b1;
                    r_rdata <= '0;
                end
            end
            // Sub-word stores reuse r_wdata to hold the merged write word
            if (r_state == RD_WAIT && w_rdy) begin
                if (r_we) r_wdata <= w_merge;
                else      r_rdata <= w_load;
            end
            if (r_state == DONE) r_fault <= 1'b0;
        end
    end
    assign bus.cpu2cache_valid   = (r_state == RD_REQ) | (r_state == WR_REQ);
    assign bus.cpu2cache_rw      = (r_state == WR_REQ);
    assign bus.cpu2cache_addr    = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.cpu2cache_data_in = r_wdata;
    assign bus.lsu_stall         = bus.lsu_req_valid & (r_state != DONE);
    assign bus.lsu_rdata         = r_rdata;
    assign bus.lsu_fault         = r_fault;
endmodule

// File: tb/tb_lsu_cache_port.sv
// tb_lsu_cache_port: directed vector table plus hand sequences against a small word-memory cache model.
module tb_lsu_cache_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    lsu_cache_port_if #(.ADDR_W(32), .DATA_W(32)) bus();
    lsu_cache_port #(.ADDR_W(32), .DATA_W(32)) dut (.iCLK(clk), .iRST_n(rst_n), .bus(bus));
    logic [31:0] mem [16];
    logic [31:0] m_dout;
    logic        m_rdy;
    logic        hold = 1'b0;
    int          m_busy;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_val = 0;
    logic [31:0] last_addr = 32'h0;
    int          errors = 0;
    int          checks = 0;
    assign bus.cache2cpu_ready    = m_rdy & ~hold;
    assign bus.cache2cpu_data_out = m_dout;
    // Cache: accepts on valid&ready, then ready drops for one cycle before completing
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy  <= 1'b1;
            m_busy <= 0;
            m_dout <= 32'h0;
        end else begin
            if (bus.cpu2cache_valid) n_val <= n_val + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_rdy <= 1'b1;
            end else if (bus.cpu2cache_valid && bus.cache2cpu_ready) begin
                m_rdy     <= 1'b0;
                m_busy    <= 1;
                last_addr <= bus.cpu2cache_addr;
                if (bus.cpu2cache_rw) begin
                    mem[bus.cpu2cache_addr[5:2]] <= bus.cpu2cache_data_in;
                    n_wr <= n_wr + 1;
                end else begin
                    m_dout <= mem[bus.cpu2cache_addr[5:2]];
                    n_rd <= n_rd + 1;
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt, output int cyc);
        @(negedge clk);
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_req_we     = we;
        bus.lsu_req_funct3 = f3;
        bus.lsu_req_addr   = a;
        bus.lsu_req_wdata  = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.lsu_stall) begin
                bus.lsu_req_addr   = a ^ 32'hFFFF_FFF0;
                bus.lsu_req_wdata  = ~wd;
                bus.lsu_req_funct3 = 3'b111;
            end
        end while (bus.lsu_stall && cyc < 60);
        rd  = bus.lsu_rdata;
        flt = bus.lsu_fault;
        bus.lsu_req_valid = 1'b0;
    endtask
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        flt;
        int          nrd;
        int          nwr;
    } vec_t;
    vec_t v[$];
    initial begin
        logic [31:0] rd;
        logic        flt;
        int          cyc, r0, w0, v0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_we     = 1'b0;
        bus.lsu_req_funct3 = 3'b000;
        bus.lsu_req_addr   = 32'h0;
        bus.lsu_req_wdata  = 32'h0;
        v.push_back('{1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h00000000, 1'b0, 0, 1});
        v.push_back('{1'b0, 3'b010, 32'h4, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0});
        v.push_back('{1'b1, 3'b000, 32'h5, 32'hAAAAAA55, 32'hDEADBEEF, 1'b0, 1, 1});
        v.push_back('{1'b0, 3'b010, 32'h4, 32'h0,        32'hDEAD55EF, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b000, 32'h7, 32'h0,        32'hFFFFFFDE, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b100, 32'h7, 32'h0,        32'h000000DE, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b001, 32'h6, 32'h0,        32'hFFFFDEAD, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b101, 32'h6, 32'h0,        32'h0000DEAD, 1'b0, 1, 0});
        v.push_back('{1'b1, 3'b001, 32'h6, 32'hBBBB1234, 32'h0000DEAD, 1'b0, 1, 1});
        v.push_back('{1'b0, 3'b010, 32'h4, 32'h0,        32'h123455EF, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b000, 32'h5, 32'h0,        32'h00000055, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b000, 32'h4, 32'h0,        32'hFFFFFFEF, 1'b0, 1, 0});
        v.push_back('{1'b0, 3'b001, 32'h4, 32'h0,        32'h000055EF, 1'b0, 1, 0});
        v.push_back('{1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h000055EF, 1'b0, 0, 1});
        v.push_back('{1'b0, 3'b001, 32'h3, 32'h0,        32'h00000000, 1'b1, 0, 0});
        v.push_back('{1'b1, 3'b010, 32'h6, 32'h11111111, 32'h00000000, 1'b1, 0, 0});
        v.push_back('{1'b0, 3'b011, 32'h8, 32'h0,        32'h00000000, 1'b1, 0, 0});
        v.push_back('{1'b1, 3'b100, 32'h8, 32'h0,        32'h00000000, 1'b1, 0, 0});
        v.push_back('{1'b0, 3'b110, 32'h8, 32'h0,        32'h00000000, 1'b1, 0, 0});
        v.push_back('{1'b0, 3'b010, 32'hA, 32'h0,        32'h00000000, 1'b1, 0, 0});
        v.push_back('{1'b0, 3'b010, 32'h8, 32'h0,        32'hCAFEF00D, 1'b0, 1, 0});
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, bus.cpu2cache_valid}, 32'h0);
        chk("rst_addr", bus.cpu2cache_addr, 32'h0);
        chk("rst_data_in", bus.cpu2cache_data_in, 32'h0);
        chk("rst_rw", {31'b0, bus.cpu2cache_rw}, 32'h0);
        chk("rst_rdata", bus.lsu_rdata, 32'h0);
        chk("rst_fault", {31'b0, bus.lsu_fault}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_stall", {31'b0, bus.lsu_stall}, 32'h0);
        foreach (v[i]) begin
            r0 = n_rd; w0 = n_wr; v0 = n_val;
            run(v[i].we, v[i].f3, v[i].a, v[i].wd, rd, flt, cyc);
            chk($sformatf("v%0d_timeout", i), {31'b0, cyc < 60}, 32'h1);
            chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d_fault", i), {31'b0, flt}, {31'b0, v[i].flt});
            chk($sformatf("v%0d_reads", i), n_rd - r0, v[i].nrd);
            chk($sformatf("v%0d_writes", i), n_wr - w0, v[i].nwr);
            if (v[i].flt) begin
                chk($sformatf("v%0d_stall_cycles", i), cyc, 1);
                chk($sformatf("v%0d_no_valid", i), n_val - v0, 0);
                @(negedge clk);
                chk($sformatf("v%0d_fault_clear", i), {31'b0, bus.lsu_fault}, 32'h0);
            end else begin
                chk($sformatf("v%0d_addr", i), last_addr, v[i].a & 32'hFFFF_FFFC);
            end
        end
        // Cache stalls the request phase: valid/addr must hold until accepted
        @(negedge clk);
        hold = 1'b1;
        r0 = n_rd;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_req_we     = 1'b0;
        bus.lsu_req_funct3 = 3'b010;
        bus.lsu_req_addr   = 32'h4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, bus.cpu2cache_valid}, 32'h1);
            chk("hold_addr", bus.cpu2cache_addr, 32'h4);
            chk("hold_rw", {31'b0, bus.cpu2cache_rw}, 32'h0);
            chk("hold_stall", {31'b0, bus.lsu_stall}, 32'h1);
        end
        hold = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.lsu_stall && cyc < 60);
        chk("hold_timeout", {31'b0, cyc < 60}, 32'h1);
        chk("hold_rdata", bus.lsu_rdata, 32'h123455EF);
        chk("hold_reads", n_rd - r0, 1);
        bus.lsu_req_valid = 1'b0;
        // Reset asserted while the read is outstanding
        @(negedge clk);
        bus.lsu_req_valid = 1'b1;
        @(negedge clk);
        chk("rw_req_valid", {31'b0, bus.cpu2cache_valid}, 32'h1);
        @(negedge clk);
        chk("rw_wait_valid", {31'b0, bus.cpu2cache_valid}, 32'h0);
        chk("rw_wait_stall", {31'b0, bus.lsu_stall}, 32'h1);
        bus.lsu_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, bus.cpu2cache_valid}, 32'h0);
        chk("arst_addr", bus.cpu2cache_addr, 32'h0);
        chk("arst_data_in", bus.cpu2cache_data_in, 32'h0);
        chk("arst_rw", {31'b0, bus.cpu2cache_rw}, 32'h0);
        chk("arst_rdata", bus.lsu_rdata, 32'h0);
        chk("arst_fault", {31'b0, bus.lsu_fault}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = n_rd;
        run(1'b0, 3'b010, 32'h8, 32'h0, rd, flt, cyc);
        chk("post_rst_timeout", {31'b0, cyc < 60}, 32'h1);
        chk("post_rst_rdata", rd, 32'hCAFEF00D);
        chk("post_rst_fault", {31'b0, flt}, 32'h0);
        chk("post_rst_reads", n_rd - r0, 1);
        chk("post_rst_addr", last_addr, 32'h8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
